// File: rtl/pwm_motor_ctrl.sv
// pwm_motor_ctrl: tick-driven PWM generator with duty ramping and H-bridge
// direction control (brake, dead period, reverse).
`default_nettype none

module pwm_motor_ctrl #(
  parameter int PERIOD    = 100,
  parameter int RAMP_STEP = 1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_tick_clk,
  input  logic       i_enable,
  input  logic       i_dir,
  input  logic [6:0] i_duty,
  output logic       o_pwm,
  output logic       o_in1,
  output logic       o_in2,
  output logic [6:0] o_duty_cur,
  output logic       o_period_start
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_run   = 2'd1;
  localparam logic [1:0] c_brake = 2'd2;
  localparam logic [1:0] c_dead  = 2'd3;

  localparam logic [6:0] c_period = 7'(PERIOD);
  localparam logic [6:0] c_last   = 7'(PERIOD - 1);
  localparam logic [6:0] c_step   = 7'(RAMP_STEP);

  logic       tick_d_q, tick_d_d;
  logic [6:0] cnt_q, cnt_d;
  logic [1:0] state_q, state_d;
  logic       dir_act_q, dir_act_d;
  logic [6:0] duty_cur_q, duty_cur_d;
  logic       pwm_q, pwm_d;
  logic       in1_q, in1_d;
  logic       in2_q, in2_d;
  logic       period_start_q, period_start_d;

  logic       w_tick;
  logic       w_boundary;
  logic       w_drive;
  logic [6:0] w_target;

  // Moves cur toward tgt by at most c_step without overshooting.
  function automatic logic [6:0] ramp(input logic [6:0] cur, input logic [6:0] tgt);
    logic [6:0] diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      return cur + ((diff > c_step) ? c_step : diff);
    end else begin
      diff = cur - tgt;
      return cur - ((diff > c_step) ? c_step : diff);
    end
  endfunction

  always_comb begin
    w_tick     = i_tick_clk & ~tick_d_q;
    w_boundary = w_tick && (cnt_q == c_last);
    w_target   = (i_duty > c_period) ? c_period : i_duty;

    tick_d_d   = i_tick_clk;
    cnt_d      = cnt_q;
    state_d    = state_q;
    dir_act_d  = dir_act_q;
    duty_cur_d = duty_cur_q;

    if (w_tick) begin
      cnt_d = w_boundary ? 7'd0 : cnt_q + 7'd1;
    end

    // Disable wins over a coincident boundary; a boundary entering RUN
    // applies its first ramp step immediately.
    if (!i_enable) begin
      state_d    = c_idle;
      duty_cur_d = 7'd0;
    end else if (w_boundary) begin
      case (state_q)
        c_idle: begin
          state_d    = c_run;
          dir_act_d  = i_dir;
          duty_cur_d = ramp(duty_cur_q, w_target);
        end
        c_run: begin
          if (i_dir != dir_act_q) begin
            state_d = c_brake;
          end else begin
            duty_cur_d = ramp(duty_cur_q, w_target);
          end
        end
        c_brake: begin
          duty_cur_d = ramp(duty_cur_q, 7'd0);
          if (duty_cur_d == 7'd0) begin
            state_d = c_dead;
          end
        end
        c_dead: begin
          state_d    = c_run;
          dir_act_d  = i_dir;
          duty_cur_d = ramp(duty_cur_q, w_target);
        end
        default: state_d = c_idle;
      endcase
    end

    w_drive        = i_enable && ((state_q == c_run) || (state_q == c_brake));
    pwm_d          = i_enable && (duty_cur_q > cnt_q);
    in1_d          = w_drive & ~dir_act_q;
    in2_d          = w_drive & dir_act_q;
    period_start_d = i_enable & w_boundary;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tick_d_q       <= 1'b0;
      cnt_q          <= 7'd0;
      state_q        <= c_idle;
      dir_act_q      <= 1'b0;
      duty_cur_q     <= 7'd0;
      pwm_q          <= 1'b0;
      in1_q          <= 1'b0;
      in2_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      tick_d_q       <= tick_d_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      dir_act_q      <= dir_act_d;
      duty_cur_q     <= duty_cur_d;
      pwm_q          <= pwm_d;
      in1_q          <= in1_d;
      in2_q          <= in2_d;
      period_start_q <= period_start_d;
    end
  end

  assign o_pwm          = pwm_q;
  assign o_in1          = in1_q;
  assign o_in2          = in2_q;
  assign o_duty_cur     = duty_cur_q;
  assign o_period_start = period_start_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_motor_ctrl.sv
// tb_pwm_motor_ctrl: directed + randomized checks of pwm_motor_ctrl against a
// period-level reference model.
`default_nettype none

module tb_pwm_motor_ctrl;

  localparam int P   = 20;
  localparam int R   = 3;
  localparam int TH  = 2;            // tick level toggles every TH clocks
  localparam int WIN = P * 2 * TH;   // clocks per PWM period

  typedef enum int {M_IDLE, M_RUN, M_BRAKE, M_DEAD} mstate_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_clk;
  logic       en;
  logic       dir;
  logic [6:0] duty;
  logic       pwm, in1, in2, ps;
  logic [6:0] duty_cur;

  int      n_cmp = 0;
  int      n_bad = 0;
  mstate_t m_st;
  int      m_duty;
  bit      m_dir;

  pwm_motor_ctrl #(.PERIOD(P), .RAMP_STEP(R)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_tick_clk    (tick_clk),
    .i_enable      (en),
    .i_dir         (dir),
    .i_duty        (duty),
    .o_pwm         (pwm),
    .o_in1         (in1),
    .o_in2         (in2),
    .o_duty_cur    (duty_cur),
    .o_period_start(ps)
  );

  always #5 clk = ~clk;

  initial begin
    tick_clk = 1'b0;
    forever begin
      repeat (TH) @(negedge clk);
      tick_clk = ~tick_clk;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  function automatic int toward(input int cur, input int tgt);
    int d;
    d = (tgt > cur) ? tgt - cur : cur - tgt;
    if (d > R) d = R;
    return (tgt > cur) ? cur + d : cur - d;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_duty = 0; m_dir = 1'b0;
  endtask

  // Period-level rules applied at one boundary with the inputs seen there.
  task automatic model_boundary(input bit d, input int req);
    int tgt;
    tgt = (req > P) ? P : req;
    case (m_st)
      M_IDLE, M_DEAD: begin m_st = M_RUN; m_dir = d; m_duty = toward(m_duty, tgt); end
      M_RUN: if (d != m_dir) m_st = M_BRAKE; else m_duty = toward(m_duty, tgt);
      M_BRAKE: begin m_duty = toward(m_duty, 0); if (m_duty == 0) m_st = M_DEAD; end
    endcase
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_pwm"}, pwm, 0);
    chk({tag, "_in1"}, in1, 0);
    chk({tag, "_in2"}, in2, 0);
    chk({tag, "_ps"}, ps, 0);
    chk({tag, "_duty"}, duty_cur, 0);
  endtask

  // Waits (bounded) for a period start while the block must be idle.
  task automatic wait_sync(input int limit, output int waited);
    waited = 0;
    while (1) begin
      @(negedge clk);
      waited++;
      if (ps === 1'b1) break;
      chk("idle_pwm", pwm, 0);
      chk("idle_legs", {in1, in2}, 0);
      if (waited >= limit) begin
        chk("sync_timeout", waited, 0);
        finish_run();
      end
    end
    model_boundary(dir, duty);
  endtask

  // Called on the sample showing o_period_start; checks nj samples of this
  // period. A full window ends on the next period start and updates the model.
  task automatic run_period(input bit nd, input int mid, input int fin, input int nj);
    bit e1, e2;
    chk("duty_cur", duty_cur, m_duty);
    e1 = (m_st == M_RUN || m_st == M_BRAKE) && !m_dir;
    e2 = (m_st == M_RUN || m_st == M_BRAKE) && m_dir;
    for (int j = 0; j < nj; j++) begin
      @(negedge clk);
      chk("pwm", pwm, (m_duty > j / (2 * TH)) ? 1 : 0);
      chk("in1", in1, e1);
      chk("in2", in2, e2);
      chk("legs_excl", in1 & in2, 0);
      chk("period_start", ps, (j == WIN - 1) ? 1 : 0);
      if (j == 10) duty = 7'(mid);
      if (j == 40) dir = nd;
      if (j == 60) duty = 7'(fin);
    end
    if (nj == WIN) model_boundary(dir, duty);
  endtask

  initial begin
    int w;
    bit nd;
    int fin;
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; duty = 7'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst_n = 1'b1;
    en = 1'b1; duty = 7'd15;

    wait_sync(3 * WIN, w);
    chk("first_boundary_latency", (w >= WIN - 4 && w <= WIN + 4) ? 1 : 0, 1);

    // Ramp up forward to 15, then reverse: brake, dead period, ramp reverse.
    for (int k = 0; k < 6; k++) run_period(1'b0, $urandom_range(0, 127), 15, WIN);
    for (int k = 0; k < 12; k++) run_period(1'b1, $urandom_range(0, 127), 15, WIN);

    // Random direction flips and duty requests, including clamped values.
    for (int k = 0; k < 30; k++) begin
      nd  = ($urandom_range(0, 3) == 0) ? ~dir : dir;
      fin = ($urandom_range(0, 3) == 0) ? $urandom_range(P + 1, 127) : $urandom_range(0, P);
      run_period(nd, $urandom_range(0, 127), fin, WIN);
    end

    // Settle at full duty, then drop enable mid-period.
    for (int k = 0; k < 12; k++) run_period(dir, $urandom_range(0, 127), P, WIN);
    run_period(dir, 0, P, 7);
    en = 1'b0;
    @(negedge clk);
    chk_quiet("disable");
    model_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk_quiet("disabled");
    end

    en = 1'b1; dir = 1'b0; duty = 7'(P);
    wait_sync(2 * WIN, w);
    for (int k = 0; k < 8; k++) run_period(1'b0, $urandom_range(0, 127), P, WIN);

    // Asynchronous reset in the middle of a period, away from any clock edge.
    run_period(1'b0, 0, P, 40);
    #2 rst_n = 1'b0;
    #1 chk_quiet("async_reset");
    model_reset();
    repeat (3) @(negedge clk);
    chk_quiet("in_reset");
    rst_n = 1'b1; dir = 1'b1; duty = 7'd9;
    wait_sync(3 * WIN, w);
    chk("restart_latency", (w >= WIN - 4 && w <= WIN + 4) ? 1 : 0, 1);
    for (int k = 0; k < 4; k++) run_period(1'b1, $urandom_range(0, 127), 9, WIN);

    finish_run();
  end

  initial begin
    #2000000;
    chk("global_timeout", 0, 1);
    finish_run();
  end

endmodule

`default_nettype wire

// File: doc/pwm_motor_ctrl.md
PWM_MOTOR_CTRL -- requirements
Module: pwm_motor_ctrl

Interface
REQ-001 Parameter PERIOD, default 100: PWM counter steps per PWM period.
REQ-002 Parameter RAMP_STEP, default 1: maximum change of active duty per PWM period.
REQ-003 i_clk  input  1  sole system clock; all state updates on its rising edge.
REQ-004 i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_tick_clk  input  1  divided clock level generated from i_clk, e.g. toggling every 50 i_clk cycles; sampled as data, never used as a clock.
REQ-006 i_enable  input  1  motor enable; 1 = drive.
REQ-007 i_dir  input  1  requested direction; 0 = forward, 1 = reverse.
REQ-008 i_duty  input  7  requested duty in steps, 0..PERIOD; values above PERIOD SHALL be clamped to PERIOD.
REQ-009 o_pwm  output  1  PWM drive, registered.
REQ-010 o_in1  output  1  H-bridge forward leg, registered.
REQ-011 o_in2  output  1  H-bridge reverse leg, registered.
REQ-012 o_duty_cur  output  7  active duty currently applied.
REQ-013 o_period_start  output  1  one-i_clk pulse at each PWM period wrap.

Function
REQ-014 The block SHALL rising-edge-detect i_tick_clk using one register: tick = i_tick_clk & ~tick_d; one tick per divided-clock period.
REQ-015 Counter cnt, 0..PERIOD-1, SHALL increment only on tick and wrap from PERIOD-1 to 0; the wrap tick is the period boundary.
REQ-016 o_period_start SHALL be 1 for exactly the i_clk cycle after a boundary tick.
REQ-017 Target duty SHALL be sampled (clamped) only at the boundary; mid-period i_duty changes SHALL have no effect until the next boundary.
REQ-018 At each boundary in RUN, duty_cur SHALL move toward target by min(RAMP_STEP, |target-duty_cur|); no overshoot.
REQ-019 o_pwm SHALL be registered as (duty_cur > cnt) with one i_clk latency; duty 0 gives constant 0; duty PERIOD gives constant 1.
REQ-020 States: IDLE, RUN, BRAKE, DEAD.
REQ-021 IDLE: duty_cur=0, o_pwm=0, o_in1=o_in2=0. When i_enable=1, go to RUN at the next boundary and latch i_dir as the active direction.
REQ-022 RUN: o_in1=~dir_act, o_in2=dir_act. If i_dir!=dir_act at a boundary, go to BRAKE.
REQ-023 BRAKE: target is forced to 0 and duty_cur ramps down per REQ-018. The boundary at which duty_cur reaches 0 SHALL move the block to DEAD.
REQ-024 DEAD: both legs low and o_pwm low for one full PWM period. At the next boundary, set dir_act=i_dir, go to RUN and ramp from 0.
REQ-025 If i_dir returns to dir_act during BRAKE, the block SHALL complete BRAKE and DEAD anyway; it SHALL then re-enter RUN in the original direction.
REQ-026 i_enable=0 in any state SHALL force IDLE on the next i_clk edge, independent of tick, with duty_cur=0 and all outputs low.
REQ-027 o_in1 and o_in2 SHALL never be 1 simultaneously in any cycle.
REQ-028 Simultaneous boundary and enable deassert: the enable deassert SHALL take priority.

Reset
REQ-029 While i_reset_n=0: cnt=0, tick_d=0, duty_cur=0, state=IDLE, dir_act=0, and o_pwm, o_in1, o_in2, o_period_start all 0; applied asynchronously.
REQ-030 Reset asserted mid-period SHALL abort immediately; after release, operation SHALL start from cnt=0 in IDLE.

Verification
REQ-031 i_tick_clk period 100 clk, i_enable=1, i_dir=0, i_duty=50, RAMP_STEP=100 -> after the first boundary: o_in1=1, o_in2=0, o_pwm high 50 ticks (5000 clk) of every 100 ticks; o_period_start every 10000 clk.
REQ-032 RAMP_STEP=1, duty 0->30 -> o_duty_cur rises by 1 per period and reaches 30 after 30 boundaries; no further change.
REQ-033 i_duty=120 -> clamped to 100; o_pwm constantly 1. i_duty=0 -> o_pwm constantly 0.
REQ-034 In RUN at duty 5 with RAMP_STEP=1, toggle i_dir -> 5 periods of descending duty, then 1 period with o_in1=o_in2=0, then o_in2=1 and ramp up. Both legs never high together.
REQ-035 i_duty changed mid-period -> o_pwm pattern unchanged until the next boundary.
REQ-036 Deassert i_enable mid-period -> all outputs 0 one clk later. Assert i_reset_n=0 mid-period -> outputs 0 asynchronously; on release, IDLE with cnt=0.
